// File: rtl/pong_ctrl.sv
// Pong game controller: serve / play / point FSM, paddle collision detection and scoring.
// Optional rally speed-up (multi-cycle ball_step bursts) is built when PONG_SPEEDUP_EN is defined.
module pong_ctrl #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 32,
   parameter int PADDLE_H    = 8,
   parameter int PADDLE_X    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic [5:0] ball_x,
   input  logic [5:0] ball_y,
   input  logic [3:0] ball_radius,
   input  logic [5:0] paddle_l_y,
   input  logic [5:0] paddle_r_y,
   output logic       ball_rst,
   output logic       ball_step,
   output logic [3:0] angle,
   output logic       flip_x,
   output logic       flip_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [2:0] state,
   output logic [1:0] winner,
   output logic [1:0] speed_level
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_e;

   localparam int SERVE_CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

   state_e              state_q, state_d;
   logic [3:0]          score_l_q, score_l_d, score_r_q, score_r_d;
   logic [3:0]          angle_q, angle_d, hits_q, hits_d, pt_score;
   logic [1:0]          winner_q, winner_d;
   logic                flip_x_q, flip_x_d, flip_y_q, flip_y_d;
   logic                server_q, server_d, scorer_q, scorer_d;  // 0 = left, 1 = right
   logic                arm_l_q, arm_l_d, arm_r_q, arm_r_d;
   logic [SERVE_CW-1:0] serve_cnt_q, serve_cnt_d;
`ifdef PONG_SPEEDUP_EN
   logic [1:0]          burst_q, burst_d;
`endif

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Geometry is widened to 7 bits so coordinate + radius / height sums never wrap.
   logic [6:0] bx, by, rad, pl, pr;
   logic       left_contact, right_contact, hit_l, hit_r, edge_l, edge_r;

   always_comb begin
      bx            = {1'b0, ball_x};
      by            = {1'b0, ball_y};
      rad           = {3'b000, ball_radius};
      pl            = {1'b0, paddle_l_y};
      pr            = {1'b0, paddle_r_y};
      left_contact  = bx <= 7'(PADDLE_X) + rad;
      right_contact = bx + rad >= 7'(63 - PADDLE_X);
      hit_l         = by >= pl && by <= pl + 7'(PADDLE_H - 1);
      hit_r         = by >= pr && by <= pr + 7'(PADDLE_H - 1);
      edge_l        = by <= pl + 7'd1 || by + 7'd1 >= pl + 7'(PADDLE_H - 1);
      edge_r        = by <= pr + 7'd1 || by + 7'd1 >= pr + 7'(PADDLE_H - 1);
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      winner_d    = winner_q;
      angle_d     = angle_q;
      hits_d      = hits_q;
      server_d    = server_q;
      scorer_d    = scorer_q;
      arm_l_d     = arm_l_q;
      arm_r_d     = arm_r_q;
      serve_cnt_d = serve_cnt_q;
      flip_x_d    = 1'b0;
      flip_y_d    = 1'b0;
      pt_score    = sat_inc(scorer_q ? score_r_q : score_l_q);

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               score_l_d   = '0;
               score_r_d   = '0;
               winner_d    = '0;
               server_d    = 1'b0;
               serve_cnt_d = '0;
               state_d     = S_SERVE;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (serve_cnt_q == SERVE_CW'(SERVE_DELAY - 1)) begin
                  serve_cnt_d = '0;
                  hits_d      = '0;
                  angle_d     = server_q ? 4'd11 : 4'd1;
                  arm_l_d     = 1'b1;
                  arm_r_d     = 1'b1;
                  state_d     = S_PLAY;
               end else begin
                  serve_cnt_d = serve_cnt_q + 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (!left_contact)  arm_l_d = 1'b1;
               if (!right_contact) arm_r_d = 1'b1;
               if (left_contact && arm_l_q) begin
                  if (hit_l) begin
                     flip_x_d = 1'b1;
                     flip_y_d = edge_l;
                     arm_l_d  = 1'b0;
                     hits_d   = sat_inc(hits_q);
                  end else begin
                     scorer_d = 1'b1;
                     state_d  = S_POINT;
                  end
               end else if (right_contact && arm_r_q) begin
                  if (hit_r) begin
                     flip_x_d = 1'b1;
                     flip_y_d = edge_r;
                     arm_r_d  = 1'b0;
                     hits_d   = sat_inc(hits_q);
                  end else begin
                     scorer_d = 1'b0;
                     state_d  = S_POINT;
                  end
               end
            end
         end
         S_POINT: begin
            if (scorer_q) score_r_d = pt_score;
            else          score_l_d = pt_score;
            server_d = ~scorer_q;
            if (pt_score == 4'(WIN_SCORE)) begin
               winner_d = scorer_q ? 2'd2 : 2'd1;
               state_d  = S_OVER;
            end else begin
               serve_cnt_d = '0;
               state_d     = S_SERVE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef PONG_SPEEDUP_EN
      // A hit (flip) or miss (leaving PLAY) on this tick cancels the remaining burst.
      burst_d = '0;
      if (state_q == S_PLAY) begin
         if (frame_tick)
            burst_d = (state_d == S_PLAY && !flip_x_d) ? hits_q[3:2] : 2'd0;
         else if (burst_q != 2'd0)
            burst_d = burst_q - 2'd1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         score_l_q   <= '0;
         score_r_q   <= '0;
         winner_q    <= '0;
         angle_q     <= '0;
         hits_q      <= '0;
         server_q    <= 1'b0;
         scorer_q    <= 1'b0;
         arm_l_q     <= 1'b1;
         arm_r_q     <= 1'b1;
         serve_cnt_q <= '0;
         flip_x_q    <= 1'b0;
         flip_y_q    <= 1'b0;
`ifdef PONG_SPEEDUP_EN
         burst_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         winner_q    <= winner_d;
         angle_q     <= angle_d;
         hits_q      <= hits_d;
         server_q    <= server_d;
         scorer_q    <= scorer_d;
         arm_l_q     <= arm_l_d;
         arm_r_q     <= arm_r_d;
         serve_cnt_q <= serve_cnt_d;
         flip_x_q    <= flip_x_d;
         flip_y_q    <= flip_y_d;
`ifdef PONG_SPEEDUP_EN
         burst_q     <= burst_d;
`endif
      end
   end

   always_comb begin
      ball_rst    = (state_q != S_PLAY);
`ifdef PONG_SPEEDUP_EN
      ball_step   = (state_q == S_PLAY) && (frame_tick || burst_q != 2'd0);
      speed_level = hits_q[3:2];
`else
      ball_step   = (state_q == S_PLAY) && frame_tick;
      speed_level = 2'd0;
`endif
   end

   assign state   = state_q;
   assign angle   = angle_q;
   assign flip_x  = flip_x_q;
   assign flip_y  = flip_y_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign winner  = winner_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Self-checking bench for pong_ctrl: directed vector table, hand sequences and a randomized run,
// all shadowed every cycle by a behavioural game model.
module tb_pong_ctrl;

   localparam int WIN_SCORE   = 7;
   localparam int SERVE_DELAY = 32;
   localparam int PADDLE_H    = 8;
   localparam int PADDLE_X    = 2;
   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

   logic       clk, reset, start, frame_tick;
   logic [5:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
   logic [3:0] ball_radius;
   logic       ball_rst, ball_step, flip_x, flip_y;
   logic [3:0] angle, score_l, score_r;
   logic [2:0] state;
   logic [1:0] winner, speed_level;

   pong_ctrl #(
      .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY), .PADDLE_H(PADDLE_H), .PADDLE_X(PADDLE_X)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
      .ball_x(ball_x), .ball_y(ball_y), .ball_radius(ball_radius),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .ball_rst(ball_rst), .ball_step(ball_step), .angle(angle),
      .flip_x(flip_x), .flip_y(flip_y), .score_l(score_l), .score_r(score_r),
      .state(state), .winner(winner), .speed_level(speed_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   bit mdl_chk  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural game model ----------------
   int m_mode, m_sl, m_sr, m_win, m_angle, m_fx, m_fy, m_server, m_scorer;
   int m_arm_l, m_arm_r, m_ticks, m_hits, m_burst;

   task automatic model_reset();
      m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_angle = 0; m_fx = 0; m_fy = 0;
      m_server = 0; m_scorer = 0; m_arm_l = 1; m_arm_r = 1; m_ticks = 0; m_hits = 0; m_burst = 0;
   endtask

   function automatic int m_speed();
`ifdef PONG_SPEEDUP_EN
      return (m_hits / 4 > 3) ? 3 : m_hits / 4;
`else
      return 0;
`endif
   endfunction

   // One side's paddle event: hit inside the span, otherwise the other side scores.
   task automatic side_event(input int side, input int by, input int py);
      if (by >= py && by <= py + PADDLE_H - 1) begin
         m_fx = 1;
         m_fy = ((by - py) < 2 || (py + PADDLE_H - 1 - by) < 2) ? 1 : 0;
         if (side == 0) m_arm_l = 0; else m_arm_r = 0;
         m_hits = (m_hits < 15) ? m_hits + 1 : 15;
      end else begin
         m_scorer = 1 - side;
         m_mode   = M_POINT;
      end
   endtask

   task automatic model_update();
      int bx, by, r, pl, pr, ns;
      bit lc, rc, evt;
      bx = int'(ball_x); by = int'(ball_y); r = int'(ball_radius);
      pl = int'(paddle_l_y); pr = int'(paddle_r_y);
      if (reset) begin
         model_reset();
         return;
      end
      m_fx = 0; m_fy = 0;
      case (m_mode)
         M_IDLE, M_OVER: if (start) begin
            m_sl = 0; m_sr = 0; m_win = 0; m_server = 0; m_ticks = 0; m_mode = M_SERVE;
         end
         M_SERVE: if (frame_tick) begin
            m_ticks++;
            if (m_ticks == SERVE_DELAY) begin
               m_mode = M_PLAY; m_ticks = 0; m_hits = 0; m_arm_l = 1; m_arm_r = 1;
               m_angle = (m_server == 0) ? 1 : 11;
            end
         end
         M_PLAY: begin
            if (frame_tick) begin
               lc  = (bx <= PADDLE_X + r);
               rc  = (bx >= 63 - PADDLE_X - r);
               evt = 0;
               if (lc && m_arm_l != 0) begin
                  evt = 1; side_event(0, by, pl);
               end else if (rc && m_arm_r != 0) begin
                  evt = 1; side_event(1, by, pr);
               end
               if (!lc) m_arm_l = 1;
               if (!rc) m_arm_r = 1;
               m_burst = evt ? 0 : m_speed();
            end else if (m_burst > 0) begin
               m_burst--;
            end
         end
         M_POINT: begin
            if (m_scorer == 0) begin
               m_sl = (m_sl < 15) ? m_sl + 1 : 15; ns = m_sl;
            end else begin
               m_sr = (m_sr < 15) ? m_sr + 1 : 15; ns = m_sr;
            end
            m_server = 1 - m_scorer;
            if (ns == WIN_SCORE) begin
               m_win = m_scorer + 1; m_mode = M_OVER;
            end else begin
               m_mode = M_SERVE; m_ticks = 0;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic model_check();
      check("state", state, m_mode);
      check("ball_rst", ball_rst, (m_mode != M_PLAY) ? 1 : 0);
      check("ball_step", ball_step, (m_mode == M_PLAY && (frame_tick || m_burst > 0)) ? 1 : 0);
      check("angle", angle, m_angle);
      check("flip_x", flip_x, m_fx);
      check("flip_y", flip_y, m_fy);
      check("score_l", score_l, m_sl);
      check("score_r", score_r, m_sr);
      check("winner", winner, m_win);
      check("speed_level", speed_level, m_speed());
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic cycle();
      @(negedge clk);
      if (mdl_chk) model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit rs, input bit st, input bit ft,
                        input int bx, input int by, input int r, input int pl, input int pr);
      reset = rs; start = st; frame_tick = ft;
      ball_x = 6'(bx); ball_y = 6'(by); ball_radius = 4'(r);
      paddle_l_y = 6'(pl); paddle_r_y = 6'(pr);
   endtask

   task automatic serve_ticks();
      for (int i = 0; i < SERVE_DELAY; i++) begin
         drive(0, 0, 1, 32, 32, 2, 20, 40);
         cycle();
      end
      drive(0, 0, 0, 32, 32, 2, 20, 40);
   endtask

   typedef struct {
      bit st, ft;
      int bx, by, r;
      int e_state, e_fx, e_fy, e_sl, e_sr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit st, bit ft, int bx, int by, int r,
                               int es, int efx, int efy, int esl, int esr);
      vec_t v;
      v.st = st; v.ft = ft; v.bx = bx; v.by = by; v.r = r;
      v.e_state = es; v.e_fx = efx; v.e_fy = efy; v.e_sl = esl; v.e_sr = esr;
      return v;
   endfunction

   initial begin
      // Paddles fixed at left 20..27, right 40..47 for the table.
      vecs.push_back(mk(0, 1,  5, 21, 3, 2, 1, 1, 0, 0));  // left hit, top rows
      vecs.push_back(mk(0, 1,  5, 21, 3, 2, 0, 0, 0, 0));  // still in contact: disarmed
      vecs.push_back(mk(0, 1, 10, 21, 3, 2, 0, 0, 0, 0));  // contact gone: re-arm
      vecs.push_back(mk(0, 1,  5, 21, 3, 2, 1, 1, 0, 0));  // pulses again
      vecs.push_back(mk(1, 0,  5,  0, 3, 2, 0, 0, 0, 0));  // start ignored, no tick
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1,  5, 24, 3, 2, 1, 0, 0, 0));  // mid-paddle: no Y flip
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1,  5, 27, 3, 2, 1, 1, 0, 0));  // last paddle row
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1,  6, 50, 3, 2, 0, 0, 0, 0));  // one pixel short of contact
      vecs.push_back(mk(0, 1,  2, 22, 0, 2, 1, 0, 0, 0));  // radius 0 contact at the face
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 58, 41, 3, 2, 1, 1, 0, 0));  // right hit at contact boundary
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 57, 10, 3, 2, 0, 0, 0, 0));  // one pixel short on the right
      vecs.push_back(mk(0, 1, 58, 46, 3, 2, 1, 1, 0, 0));  // bottom-2 rows of right paddle
      vecs.push_back(mk(0, 1, 58, 10, 3, 2, 0, 0, 0, 0));  // disarmed: miss not counted
      vecs.push_back(mk(0, 1, 32, 32, 3, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 58, 10, 3, 3, 0, 0, 0, 0));  // right miss -> POINT
      vecs.push_back(mk(0, 0, 32, 32, 3, 1, 0, 0, 1, 0));  // left scores, back to SERVE

      model_reset();
      drive(1, 0, 0, 32, 32, 2, 20, 40);
      cycle();
      mdl_chk = 1;
      drive(0, 0, 0, 32, 32, 2, 20, 40);
      #1;
      check("rst.state", state, M_IDLE);
      check("rst.ball_rst", ball_rst, 1);
      check("rst.ball_step", ball_step, 0);
      check("rst.angle", angle, 0);
      check("rst.scores", {score_l, score_r}, 0);
      check("rst.winner", winner, 0);
      check("rst.flips", {flip_x, flip_y}, 0);
      check("rst.speed", speed_level, 0);

      // Serve sequence: IDLE -> SERVE -> PLAY after SERVE_DELAY ticks.
      drive(0, 1, 0, 32, 32, 2, 20, 40);
      cycle();
      check("start.state", state, M_SERVE);
      for (int i = 0; i < SERVE_DELAY - 1; i++) begin
         drive(0, 0, 1, 32, 32, 2, 20, 40);
         cycle();
      end
      check("serve31.state", state, M_SERVE);
      check("serve31.ball_rst", ball_rst, 1);
      drive(0, 0, 1, 32, 32, 2, 20, 40);
      cycle();
      drive(0, 0, 0, 32, 32, 2, 20, 40);
      #1;
      check("serve32.state", state, M_PLAY);
      check("serve32.angle", angle, 1);
      check("serve32.ball_rst", ball_rst, 0);

      foreach (vecs[i]) begin
         drive(0, vecs[i].st, vecs[i].ft, vecs[i].bx, vecs[i].by, vecs[i].r, 20, 40);
         cycle();
         check($sformatf("vec%0d.state", i), state, vecs[i].e_state);
         check($sformatf("vec%0d.flip_x", i), flip_x, vecs[i].e_fx);
         check($sformatf("vec%0d.flip_y", i), flip_y, vecs[i].e_fy);
         check($sformatf("vec%0d.score_l", i), score_l, vecs[i].e_sl);
         check($sformatf("vec%0d.score_r", i), score_r, vecs[i].e_sr);
      end

      serve_ticks();
      #1;
      check("reserve.state", state, M_PLAY);
      check("reserve.angle", angle, 11);

      // Left misses until right reaches WIN_SCORE.
      for (int i = 0; i < WIN_SCORE; i++) begin
         if (i > 0) serve_ticks();
         drive(0, 0, 1, 5, 0, 3, 20, 40);
         cycle();
         drive(0, 0, 0, 32, 32, 3, 20, 40);
         cycle();
      end
      check("over.state", state, M_OVER);
      check("over.winner", winner, 2);
      check("over.score_r", score_r, WIN_SCORE);
      check("over.score_l", score_l, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 5, 0, 3, 20, 40);
         cycle();
      end
      check("over_hold.state", state, M_OVER);
      check("over_hold.score_r", score_r, WIN_SCORE);
      drive(0, 1, 0, 32, 32, 3, 20, 40);
      cycle();
      check("restart.state", state, M_SERVE);
      check("restart.scores", {score_l, score_r}, 0);
      check("restart.winner", winner, 0);

      // Reset mid-SERVE and mid-PLAY, colliding with start and frame_tick.
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, 32, 32, 3, 20, 40);
         cycle();
      end
      drive(1, 1, 1, 32, 32, 3, 20, 40);
      cycle();
      check("rst_serve.state", state, M_IDLE);
      drive(0, 1, 0, 32, 32, 3, 20, 40);
      cycle();
      serve_ticks();
      drive(1, 1, 1, 5, 21, 3, 20, 40);
      cycle();
      drive(0, 0, 0, 32, 32, 3, 20, 40);
      #1;
      check("rst_play.state", state, M_IDLE);
      check("rst_play.flip_x", flip_x, 0);
      check("rst_play.angle", angle, 0);
      check("rst_play.ball_rst", ball_rst, 1);

`ifdef PONG_SPEEDUP_EN
      drive(0, 1, 0, 32, 32, 3, 20, 40);
      cycle();
      serve_ticks();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive(0, 0, 1, 5, 21, 3, 20, 40);
         else            drive(0, 0, 1, 58, 41, 3, 20, 40);
         cycle();
         check($sformatf("burst_hit%0d.flip_x", i), flip_x, 1);
      end
      check("speed.level", speed_level, 2);
      drive(0, 0, 1, 32, 32, 3, 20, 40);
      #1;
      check("burst0.step", ball_step, 1);
      cycle();
      drive(0, 0, 0, 32, 32, 3, 20, 40);
      #1;
      check("burst1.step", ball_step, 1);
      cycle();
      check("burst2.step", ball_step, 1);
      cycle();
      check("burst3.step", ball_step, 0);
      drive(1, 0, 1, 32, 32, 3, 20, 40);
      cycle();
      drive(0, 0, 0, 32, 32, 3, 20, 40);
      #1;
      check("rst_burst.state", state, M_IDLE);
      check("rst_burst.step", ball_step, 0);
      check("rst_burst.speed", speed_level, 0);
`endif

      // Randomized play, checked every cycle against the model.
      for (int n = 0; n < 4000; n++) begin
         int sel, bx, by, pl, pr, r;
         sel = int'($urandom_range(0, 3));
         pl  = int'($urandom_range(0, 63));
         pr  = int'($urandom_range(0, 63));
         r   = int'($urandom_range(0, 8));
         if (sel == 0)      bx = int'($urandom_range(0, 10));
         else if (sel == 1) bx = int'($urandom_range(53, 63));
         else               bx = int'($urandom_range(0, 63));
         by = ((bx < 32) ? pl : pr) + int'($urandom_range(0, 10)) - 1;
         by = by & 63;
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 1) == 1, bx, by, r, pl, pr);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
